// File: rtl/apb_wait_slave.sv
// apb_wait_slave: APB completer backed by a DEPTH-byte register memory.
// Latency: setup + (WAIT_CYCLES+1) access cycles, then PREADY high for one cycle (W+3 total).
// Backpressure: stalls the bridge via PREADY; addresses >= DEPTH complete with PSLVERR=1.
//
// Ports:
//   PCLK     - sole clock, rising edge
//   PRESET   - asynchronous active-high reset (also clears the memory)
//   PSEL     - completer select from the bridge
//   PENABLE  - access-phase indicator
//   PWRITE   - 1 = write, 0 = read
//   PADDR    - byte address (slot decode on PADDR[8] happens outside)
//   PWDATA   - write data
//   PRDATA   - registered read data, holds the last completed read
//   PREADY   - registered transfer-complete strobe, one cycle wide
//   PSLVERR  - registered error qualifier, meaningful only with PREADY

module apb_wait_slave #(
   parameter int DEPTH       = 128,  // 1..256 implemented bytes
   parameter int WAIT_CYCLES = 2     // 0..15 access-phase wait states
) (
   input  logic       PCLK,
   input  logic       PRESET,
   input  logic       PSEL,
   input  logic       PENABLE,
   input  logic       PWRITE,
   input  logic [7:0] PADDR,
   input  logic [7:0] PWDATA,
   output logic [7:0] PRDATA,
   output logic       PREADY,
   output logic       PSLVERR
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      DONE   = 2'd2
   } state_t;

   state_t     state;
   logic [3:0] wait_cnt;
   logic [7:0] addr_q;
   logic [7:0] wdata_q;
   logic       write_q;
   logic [7:0] mem [DEPTH];

   logic          addr_ok;
   logic [AW-1:0] mem_idx;
   logic          setup_seen;

   // Range check uses the full latched byte address so out-of-range
   // accesses never alias onto the implemented bytes.
   assign addr_ok    = ({1'b0, addr_q} < 9'(DEPTH));
   assign mem_idx    = addr_q[AW-1:0];
   assign setup_seen = PSEL && !PENABLE;

   always_ff @(posedge PCLK or posedge PRESET) begin
      if (PRESET) begin
         state    <= IDLE;
         wait_cnt <= 4'd0;
         addr_q   <= 8'h00;
         wdata_q  <= 8'h00;
         write_q  <= 1'b0;
         PRDATA   <= 8'h00;
         PREADY   <= 1'b0;
         PSLVERR  <= 1'b0;
         for (int i = 0; i < DEPTH; i++) begin
            mem[i] <= 8'h00;
         end
      end else begin
         case (state)
            IDLE: begin
               // An access phase with no preceding setup is not a transfer.
               if (setup_seen) begin
                  addr_q   <= PADDR;
                  write_q  <= PWRITE;
                  wdata_q  <= PWDATA;
                  wait_cnt <= 4'(WAIT_CYCLES);
                  state    <= ACCESS;
               end
            end

            ACCESS: begin
               if (!PSEL) begin
                  // Bridge abandoned the transfer: nothing commits.
                  state <= IDLE;
               end else if (PENABLE) begin
                  if (wait_cnt != 4'd0) begin
                     wait_cnt <= wait_cnt - 4'd1;
                  end else begin
                     PREADY <= 1'b1;
                     state  <= DONE;
                     if (addr_ok) begin
                        PSLVERR <= 1'b0;
                        if (write_q) begin
                           mem[mem_idx] <= wdata_q;
                        end else begin
                           PRDATA <= mem[mem_idx];
                        end
                     end else begin
                        PSLVERR <= 1'b1;
                        // Write completions never touch PRDATA, even on error.
                        if (!write_q) begin
                           PRDATA <= 8'h00;
                        end
                     end
                  end
               end
            end

            DONE: begin
               PREADY  <= 1'b0;
               PSLVERR <= 1'b0;
               // A setup presented in the PREADY cycle chains straight into
               // the next access phase with no idle gap.
               if (setup_seen) begin
                  addr_q   <= PADDR;
                  write_q  <= PWRITE;
                  wdata_q  <= PWDATA;
                  wait_cnt <= 4'(WAIT_CYCLES);
                  state    <= ACCESS;
               end else begin
                  state <= IDLE;
               end
            end

            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_apb_wait_slave.sv
// tb_apb_wait_slave: directed bench for apb_wait_slave against a transaction-level model.
// Each transfer task sets the expected bus outputs cycle by cycle from the transfer timing rules.
// A negedge compare process checks PREADY/PSLVERR/PRDATA every cycle and logs PREADY cycles.

module tb_apb_wait_slave;

   localparam int DEPTH = 128;
   localparam int W     = 2;

   logic       PCLK    = 1'b0;
   logic       PRESET  = 1'b0;
   logic       PSEL    = 1'b0;
   logic       PENABLE = 1'b0;
   logic       PWRITE  = 1'b0;
   logic [7:0] PADDR   = 8'h00;
   logic [7:0] PWDATA  = 8'h00;
   logic [7:0] PRDATA;
   logic       PREADY;
   logic       PSLVERR;

   apb_wait_slave #(
      .DEPTH       (DEPTH),
      .WAIT_CYCLES (W)
   ) dut (
      .PCLK    (PCLK),
      .PRESET  (PRESET),
      .PSEL    (PSEL),
      .PENABLE (PENABLE),
      .PWRITE  (PWRITE),
      .PADDR   (PADDR),
      .PWDATA  (PWDATA),
      .PRDATA  (PRDATA),
      .PREADY  (PREADY),
      .PSLVERR (PSLVERR)
   );

   always #5 PCLK = ~PCLK;

   int   n_chk   = 0;
   int   n_fail  = 0;
   int   cyc     = 0;
   int   t_setup = 0;
   bit   chk_en  = 1'b0;
   int   rdy_q[$];

   // Model state: byte memory, last completed read value, expected outputs.
   logic [7:0] mem_m [256];
   logic [7:0] rdata_m = 8'h00;
   logic       exp_rdy = 1'b0;
   logic       exp_err = 1'b0;
   logic [7:0] exp_rd  = 8'h00;

   always @(posedge PCLK) cyc <= cyc + 1;

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   always @(negedge PCLK) begin
      if (chk_en) begin
         check("PREADY",  {31'd0, PREADY},  {31'd0, exp_rdy});
         check("PSLVERR", {31'd0, PSLVERR}, {31'd0, exp_err});
         check("PRDATA",  {24'd0, PRDATA},  {24'd0, exp_rd});
         if (PREADY === 1'b1) rdy_q.push_back(cyc);
      end
   end

   task automatic tick();
      @(posedge PCLK);
      #1;
   endtask

   task automatic drive(input logic s, input logic en, input logic wr,
                        input logic [7:0] a, input logic [7:0] d);
      PSEL    = s;
      PENABLE = en;
      PWRITE  = wr;
      PADDR   = a;
      PWDATA  = d;
   endtask

   task automatic quiet_exp();
      exp_rdy = 1'b0;
      exp_err = 1'b0;
      exp_rd  = rdata_m;
   endtask

   task automatic model_reset();
      foreach (mem_m[i]) mem_m[i] = 8'h00;
      rdata_m = 8'h00;
      quiet_exp();
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         tick();
         drive(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
         quiet_exp();
      end
   endtask

   // One transfer: setup (unless already presented by a chained caller),
   // W+1 access cycles with scrambled bus values that must be ignored, then
   // the PREADY cycle, during which an optional chained setup is driven.
   task automatic xfer(input bit wr, input logic [7:0] a, input logic [7:0] d,
                       input bit pre_setup, input bit chain,
                       input bit cwr, input logic [7:0] ca, input logic [7:0] cd);
      if (!pre_setup) begin
         tick();
         drive(1'b1, 1'b0, wr, a, d);
         quiet_exp();
         t_setup = cyc;
      end
      for (int i = 0; i <= W; i++) begin
         tick();
         drive(1'b1, 1'b1, ~wr, ~a, ~d);
         quiet_exp();
      end
      tick();
      if (int'(a) < DEPTH) begin
         if (wr) mem_m[a] = d;
         else    rdata_m  = mem_m[a];
         exp_err = 1'b0;
      end else begin
         if (!wr) rdata_m = 8'h00;
         exp_err = 1'b1;
      end
      exp_rdy = 1'b1;
      exp_rd  = rdata_m;
      if (chain) drive(1'b1, 1'b0, cwr, ca, cd);
      else       drive(1'b1, 1'b1, ~wr, ~a, ~d);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
      $fatal(1, "watchdog expired");
   end

   initial begin
      model_reset();
      #2 PRESET = 1'b1;
      repeat (2) @(posedge PCLK);
      #1 chk_en = 1'b1;
      @(negedge PCLK);
      @(posedge PCLK);
      #1 PRESET = 1'b0;

      // Read after reset.
      xfer(1'b0, 8'h05, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
      check("rd05_data", PRDATA, 8'h00);
      idle(2);

      // Out-of-range write/read and the last valid byte.
      xfer(1'b1, 8'h80, 8'h3C, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
      check("wr80_ready", PREADY, 1);
      check("wr80_err", PSLVERR, 1);
      idle(1);
      xfer(1'b0, 8'h80, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
      check("rd80_data", PRDATA, 8'h00);
      check("rd80_err", PSLVERR, 1);
      idle(1);
      xfer(1'b0, 8'h7F, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
      check("rd7f_data", PRDATA, 8'h00);
      check("rd7f_err", PSLVERR, 0);
      idle(1);

      // Write then read back, PREADY in cycle 4 of each transfer.
      rdy_q.delete();
      xfer(1'b1, 8'h10, 8'hA5, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
      idle(1);
      check("wr10_ready_cycle", (rdy_q.size() == 1) ? rdy_q[0] - t_setup : -1, 4);
      rdy_q.delete();
      xfer(1'b0, 8'h10, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
      check("rd10_data", PRDATA, 8'hA5);
      check("rd10_err", PSLVERR, 0);
      idle(1);
      check("rd10_ready_cycle", (rdy_q.size() == 1) ? rdy_q[0] - t_setup : -1, 4);

      // Aborted write: PSEL dropped after one access cycle.
      rdy_q.delete();
      tick(); drive(1'b1, 1'b0, 1'b1, 8'h20, 8'hFF); quiet_exp();
      tick(); drive(1'b1, 1'b1, 1'b1, 8'h20, 8'hFF); quiet_exp();
      tick(); drive(1'b0, 1'b0, 1'b0, 8'h00, 8'h00); quiet_exp();
      idle(4);
      check("abort_no_ready", rdy_q.size(), 0);
      xfer(1'b0, 8'h20, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
      check("rd20_data", PRDATA, 8'h00);
      idle(1);

      // Back-to-back write then read of 0x01.
      rdy_q.delete();
      xfer(1'b1, 8'h01, 8'h11, 1'b0, 1'b1, 1'b0, 8'h01, 8'h00);
      xfer(1'b0, 8'h01, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00, 8'h00);
      check("b2b_rd_data", PRDATA, 8'h11);
      idle(1);
      check("b2b_ready_count", rdy_q.size(), 2);
      check("b2b_ready_gap", (rdy_q.size() == 2) ? rdy_q[1] - rdy_q[0] : -1, W + 2);

      // Asynchronous reset during the wait states of a write of 0x77 to 0x30.
      rdy_q.delete();
      tick(); drive(1'b1, 1'b0, 1'b1, 8'h30, 8'h77); quiet_exp();
      tick(); drive(1'b1, 1'b1, 1'b1, 8'h30, 8'h77); quiet_exp();
      tick(); drive(1'b1, 1'b1, 1'b1, 8'h30, 8'h77); quiet_exp();
      @(negedge PCLK);
      #2 PRESET = 1'b1;
      model_reset();
      #1;
      check("async_rst_prdata", PRDATA, 8'h00);
      check("async_rst_pready", PREADY, 0);
      check("async_rst_pslverr", PSLVERR, 0);
      tick(); drive(1'b0, 1'b0, 1'b0, 8'h00, 8'h00); quiet_exp();
      tick(); PRESET = 1'b0;
      idle(2);
      check("rst_no_ready", rdy_q.size(), 0);
      xfer(1'b0, 8'h30, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
      check("rd30_after_rst", PRDATA, 8'h00);
      idle(1);
      xfer(1'b0, 8'h01, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
      check("rd01_after_rst", PRDATA, 8'h00);
      idle(2);

      chk_en = 1'b0;
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
